// File: rtl/parallel_to_serial_tx.sv
// parallel_to_serial_tx
// Accepts one parallel word per valid/ready handshake and shifts it out LSB
// first as a framed word: start bit (0), data bits, optional even parity,
// stop bits (1). The line idles high and every bit lasts CLKS_PER_BIT clocks.
// All outputs come straight from flops, so the line can drive a pin directly.
module parallel_to_serial_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] inputParallelData,
   input  logic                  inputValid,
   output logic                  inputReady,
   output logic                  outputSerialData,
   output logic                  txBusy,
   output logic                  frameDone
);

   // Baud counter needs at least one bit even when every clock is a new bit.
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   // Bit counter is shared between the data phase and the stop phase.
   localparam int CNT_W  = $clog2(DATA_WIDTH + STOP_BITS + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);

   // With one clock per bit the baud counter never leaves 0.
   localparam logic SINGLE_CLK    = (CLKS_PER_BIT == 1);
   // The stop phase is a single clock long, so frameDone must rise on entry.
   localparam logic DONE_ON_ENTRY = (CLKS_PER_BIT == 1) && (STOP_BITS == 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_parity;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [BAUD_W-1:0]     r_baud;
   logic                  r_line;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_accept;
   logic                  w_baud_last;
   logic [BAUD_W-1:0]     w_baud_inc;
   logic [CNT_W-1:0]      w_cnt_inc;
   logic [DATA_WIDTH-1:0] w_shift_next;

   assign w_accept     = inputValid && r_ready;
   assign w_baud_last  = (r_baud == BAUD_LAST);
   assign w_baud_inc   = r_baud + 1'b1;
   assign w_cnt_inc    = r_bit_cnt + 1'b1;
   assign w_shift_next = r_shift >> 1;

   // Frame sequencer: state, counters and every registered output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_bit_cnt <= '0;
         r_baud    <= '0;
         r_line    <= 1'b1;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         // frameDone is a single-clock pulse; only the stop phase raises it.
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_line <= 1'b1;
               if (w_accept) begin
                  // Capture the word now so later input changes cannot leak in.
                  r_shift   <= inputParallelData;
                  r_parity  <= ^inputParallelData;
                  r_state   <= ST_START;
                  r_line    <= 1'b0;
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
                  r_baud    <= '0;
                  r_bit_cnt <= '0;
               end
            end

            ST_START: begin
               if (w_baud_last) begin
                  r_baud  <= '0;
                  r_state <= ST_DATA;
                  r_line  <= r_shift[0];
               end else begin
                  r_baud <= w_baud_inc;
               end
            end

            ST_DATA: begin
               if (w_baud_last) begin
                  r_baud <= '0;
                  if (r_bit_cnt == DATA_LAST) begin
                     r_bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        r_state <= ST_PARITY;
                        r_line  <= r_parity;
                     end else begin
                        r_state <= ST_STOP;
                        r_line  <= 1'b1;
                        r_done  <= DONE_ON_ENTRY;
                     end
                  end else begin
                     r_bit_cnt <= w_cnt_inc;
                     r_shift   <= w_shift_next;
                     r_line    <= w_shift_next[0];
                  end
               end else begin
                  r_baud <= w_baud_inc;
               end
            end

            ST_PARITY: begin
               if (w_baud_last) begin
                  r_baud    <= '0;
                  r_bit_cnt <= '0;
                  r_state   <= ST_STOP;
                  r_line    <= 1'b1;
                  r_done    <= DONE_ON_ENTRY;
               end else begin
                  r_baud <= w_baud_inc;
               end
            end

            ST_STOP: begin
               r_line <= 1'b1;
               if (w_baud_last) begin
                  r_baud <= '0;
                  if (r_bit_cnt == STOP_LAST) begin
                     // Last stop clock ends here; ready is visible next cycle.
                     r_bit_cnt <= '0;
                     r_state   <= ST_IDLE;
                     r_ready   <= 1'b1;
                     r_busy    <= 1'b0;
                  end else begin
                     // Look ahead: flag the clock that will be the final one.
                     r_bit_cnt <= w_cnt_inc;
                     r_done    <= SINGLE_CLK && (w_cnt_inc == STOP_LAST);
                  end
               end else begin
                  r_baud <= w_baud_inc;
                  r_done <= (w_baud_inc == BAUD_LAST) && (r_bit_cnt == STOP_LAST);
               end
            end

            default: begin
               r_state   <= ST_IDLE;
               r_line    <= 1'b1;
               r_ready   <= 1'b1;
               r_busy    <= 1'b0;
               r_baud    <= '0;
               r_bit_cnt <= '0;
            end
         endcase
      end
   end

   assign inputReady       = r_ready;
   assign outputSerialData = r_line;
   assign txBusy           = r_busy;
   assign frameDone        = r_done;

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Testbench for parallel_to_serial_tx.
// Two instances: defaults (8N1, 1 clk/bit) and 8E2 at 4 clks/bit.
// The reference model expands each accepted word into the per-clock
// waveform {line, ready, busy, done} it must produce and queues it; the
// monitor pops one expectation per clock and compares.
module tb_parallel_to_serial_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst;
   logic [1:0] vld;
   logic [7:0] dat [2];
   logic [1:0] rdy, line, busy, done;

   parallel_to_serial_tx #(
      .DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .STOP_BITS(1)
   ) u_dut0 (
      .clk(clk), .reset(rst[0]), .inputParallelData(dat[0]),
      .inputValid(vld[0]), .inputReady(rdy[0]), .outputSerialData(line[0]),
      .txBusy(busy[0]), .frameDone(done[0])
   );

   parallel_to_serial_tx #(
      .DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)
   ) u_dut1 (
      .clk(clk), .reset(rst[1]), .inputParallelData(dat[1]),
      .inputValid(vld[1]), .inputReady(rdy[1]), .outputSerialData(line[1]),
      .txBusy(busy[1]), .frameDone(done[1])
   );

   // Frame shape of each instance, as seen by the model.
   int cpb_k [2] = '{1, 4};
   int par_k [2] = '{0, 1};
   int sb_k  [2] = '{1, 2};

   localparam logic [3:0] IDLE_T = 4'b1100; // line=1 ready=1 busy=0 done=0

   // Expected per-clock outputs, one queue per instance.
   logic [3:0] q0 [$];
   logic [3:0] q1 [$];
   // Words still to be sent from the directed list.
   logic [7:0] send0 [$];
   logic [7:0] send1 [$];

   logic [1:0] model_rdy = 2'b11;
   logic [1:0] from_list = 2'b00;
   logic       checking  = 1'b0;
   bit         did_reset = 1'b0;
   int         reset_cd  = 0;
   int         vectors   = 0;
   int         miscompares = 0;

   // Frame as a list of bits, each repeated for the bit time.
   function automatic void push_frame(input int k, input logic [7:0] d);
      int   nb;
      logic bv;
      logic [3:0] t;
      nb = 9 + par_k[k] + sb_k[k];
      for (int b = 0; b < nb; b++) begin
         if (b == 0)                         bv = 1'b0;
         else if (b <= 8)                    bv = d[b-1];
         else if (b == 9 && par_k[k] == 1)   bv = ^d;
         else                                bv = 1'b1;
         for (int c = 0; c < cpb_k[k]; c++) begin
            t = {bv, 1'b0, 1'b1, (b == nb - 1 && c == cpb_k[k] - 1)};
            if (k == 0) q0.push_back(t);
            else        q1.push_back(t);
         end
      end
   endfunction

   // Model reaction to the inputs present at a rising edge.
   task automatic model_edge(input int k);
      if (rst[k]) begin
         if (k == 0) q0.delete();
         else        q1.delete();
      end else if (model_rdy[k] && vld[k]) begin
         push_frame(k, dat[k]);
         if (from_list[k]) begin
            if (k == 0) begin
               void'(send0.pop_front());
               if (dat[0] == 8'h3C && !did_reset) begin
                  // Reset lands on the edge closing data bit 3.
                  did_reset = 1'b1;
                  reset_cd  = 5;
               end
            end else begin
               void'(send1.pop_front());
            end
         end
      end
   endtask

   // Inputs for the next edge. phase: 0 idle, 1 directed, 2 random, 3 reset, 4 drain.
   task automatic drive(input int phase);
      for (int k = 0; k < 2; k++) begin
         rst[k]       = (phase == 3);
         from_list[k] = 1'b0;
         vld[k]       = 1'b0;
         dat[k]       = 8'($urandom);
         if (phase == 1 && k == 0 && send0.size() > 0) begin
            vld[k] = 1'b1; dat[k] = send0[0]; from_list[k] = 1'b1;
         end else if (phase == 1 && k == 1 && send1.size() > 0) begin
            vld[k] = 1'b1; dat[k] = send1[0]; from_list[k] = 1'b1;
         end else if (phase == 2) begin
            vld[k] = ($urandom_range(2) != 0);
            if ($urandom_range(149) == 0) rst[k] = 1'b1;
         end
      end
      if (reset_cd > 0) begin
         reset_cd--;
         if (reset_cd == 0) rst[0] = 1'b1;
      end
   endtask

   task automatic step(input int phase);
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      checking = 1'b1;
      #1;
      drive(phase);
   endtask

   // Monitor: one comparison per instance per clock, away from the edge.
   always @(negedge clk) begin
      if (checking) begin
         for (int k = 0; k < 2; k++) begin
            logic [3:0] e;
            logic [3:0] a;
            e = IDLE_T;
            if (k == 0 && q0.size() > 0) e = q0.pop_front();
            if (k == 1 && q1.size() > 0) e = q1.pop_front();
            model_rdy[k] = e[2];
            a = {line[k], rdy[k], busy[k], done[k]};
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL outputs inst%0d t=%0t: line/ready/busy/done got %b want %b",
                        k, $time, a, e);
            end
         end
      end
   end

   initial begin
      int guard;
      send0 = '{8'hA5, 8'h01, 8'hFF, 8'h3C, 8'h3C, 8'h00, 8'hFF, 8'h5A};
      send1 = '{8'h07, 8'h3C, 8'hA5};
      drive(3);
      repeat (2) step(3);
      repeat (5) step(0);
      guard = 0;
      while ((send0.size() > 0 || send1.size() > 0) && guard < 800) begin
         step(1);
         guard++;
      end
      if (guard >= 800) begin
         vectors++;
         miscompares++;
         $display("FAIL directed-phase timeout: words left %0d/%0d, want 0/0",
                  send0.size(), send1.size());
      end
      repeat (2500) step(2);
      repeat (150) step(4);
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
